// File: rtl/slice_block_scheduler.sv
// Ping-pong slice scheduler: fills one bank of 8x8 blocks while the other is
// presented to the entropy coder, closing slices on target count or flush.
module slice_block_scheduler #(
  parameter int BLOCKS_MAX = 32,
  parameter int CNT_W      = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CNT_W-1:0] blocks_per_slice,
  input  logic             flush,
  input  logic             blk_valid,
  output logic             blk_ready,
  output logic             wr_en,
  output logic             wr_bank,
  output logic [31:0]      wr_counter,
  output logic             slice_valid,
  output logic             slice_bank,
  output logic [CNT_W-1:0] slice_blocks,
  input  logic             slice_ack,
  output logic             flush_done,
  output logic             busy
);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(BLOCKS_MAX);

  function automatic logic [CNT_W-1:0] clamp_target(input logic [CNT_W-1:0] req);
    if (req == '0 || req > MAX_C) return MAX_C;
    return req;
  endfunction

  logic [1:0][1:0]       st_q, st_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0][CNT_W-1:0] tgt_q, tgt_d;
  logic                  wb_q, wb_d;
  logic                  rb_q, rb_d;
  logic                  pend_q, pend_d;
  logic                  pend_flush_q, pend_flush_d;
  logic                  blk_ready_q, blk_ready_d;
  logic                  wr_en_q, wr_en_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic                  flush_done_q, flush_done_d;
  logic                  accept;
  logic [CNT_W-1:0]      tgt_now;
  logic [CNT_W-1:0]      cnt_nxt;

  always_comb begin
    st_d         = st_q;
    cnt_d        = cnt_q;
    tgt_d        = tgt_q;
    wb_d         = wb_q;
    rb_d         = rb_q;
    pend_d       = pend_q;
    pend_flush_d = pend_flush_q;
    wr_en_d      = 1'b0;
    wr_bank_d    = wr_bank_q;
    wr_cnt_d     = wr_cnt_q;
    flush_done_d = 1'b0;
    accept       = blk_valid && blk_ready_q;
    tgt_now      = tgt_q[wb_q];
    cnt_nxt      = cnt_q[wb_q] + CNT_W'(1);

    if (slice_ack && st_q[rb_q] == ST_FULL) begin
      st_d[rb_q]  = ST_EMPTY;
      cnt_d[rb_q] = '0;
      rb_d        = ~rb_q;
    end

    // A pending close lands on the edge after the last write, so the memory
    // write has committed before the consumer sees slice_valid.
    if (pend_q) begin
      st_d[wb_q]   = ST_FULL;
      wb_d         = ~wb_q;
      pend_d       = 1'b0;
      pend_flush_d = 1'b0;
      flush_done_d = pend_flush_q;
    end

    if (accept) begin
      wr_en_d   = 1'b1;
      wr_bank_d = wb_q;
      wr_cnt_d  = cnt_q[wb_q];
      if (st_q[wb_q] == ST_EMPTY) begin
        st_d[wb_q]  = ST_FILLING;
        tgt_now     = clamp_target(blocks_per_slice);
        tgt_d[wb_q] = tgt_now;
      end
      cnt_d[wb_q] = cnt_nxt;
      if (cnt_nxt == tgt_now) pend_d = 1'b1;
    end

    if (flush) begin
      if (pend_q) begin
        flush_done_d = 1'b1;
      end else if (accept || (st_q[wb_q] == ST_FILLING && cnt_q[wb_q] != '0)) begin
        pend_d       = 1'b1;
        pend_flush_d = 1'b1;
      end else begin
        flush_done_d = 1'b1;
      end
    end

    blk_ready_d = !pend_d && (st_d[wb_d] == ST_EMPTY ||
                  (st_d[wb_d] == ST_FILLING && cnt_d[wb_d] < tgt_d[wb_d]));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q         <= '0;
      cnt_q        <= '0;
      tgt_q        <= '0;
      wb_q         <= 1'b0;
      rb_q         <= 1'b0;
      pend_q       <= 1'b0;
      pend_flush_q <= 1'b0;
      blk_ready_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_bank_q    <= 1'b0;
      wr_cnt_q     <= '0;
      flush_done_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      tgt_q        <= tgt_d;
      wb_q         <= wb_d;
      rb_q         <= rb_d;
      pend_q       <= pend_d;
      pend_flush_q <= pend_flush_d;
      blk_ready_q  <= blk_ready_d;
      wr_en_q      <= wr_en_d;
      wr_bank_q    <= wr_bank_d;
      wr_cnt_q     <= wr_cnt_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign blk_ready    = blk_ready_q;
  assign wr_en        = wr_en_q;
  assign wr_bank      = wr_bank_q;
  assign wr_counter   = 32'(wr_cnt_q);
  assign slice_valid  = (st_q[rb_q] == ST_FULL);
  assign slice_bank   = rb_q;
  assign slice_blocks = slice_valid ? cnt_q[rb_q] : '0;
  assign flush_done   = flush_done_q;
  assign busy         = (st_q[0] != ST_EMPTY) || (st_q[1] != ST_EMPTY);

endmodule

// File: doc/slice_block_scheduler.md
Name: slice_block_scheduler

Overview:
Sequences 8x8 coefficient blocks into a ping-pong pair of 2048-word slice memories (32 blocks x 64 words per bank). It accepts blocks from the quant stage over valid/ready and drives the block index (counter), bank select and write strobe of the array-to-memory write stage. When a slice is complete or flushed, it hands the bank to the entropy-coder side and reclaims it on acknowledge. Sits between quantiser output and slice memory / entropy encoder.

Parameters:
BLOCKS_MAX, 32, blocks per bank; memory depth = BLOCKS_MAX*64 words
CNT_W, 6, width of block counts (holds 0..BLOCKS_MAX)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
blocks_per_slice  input  CNT_W  target blocks per slice; sampled on first block of each slice
flush  input  1  single-cycle pulse: close current partial slice
blk_valid  input  1  upstream 8x8 block available
blk_ready  output  1  scheduler accepts block this cycle
wr_en  output  1  write strobe to array-to-memory stage, 1 cycle per block
wr_bank  output  1  target bank of current write
wr_counter  output  32  block index within bank (word base = wr_counter*64)
slice_valid  output  1  a completed slice is ready for the consumer
slice_bank  output  1  bank holding the presented slice
slice_blocks  output  CNT_W  number of valid blocks in presented slice (1..BLOCKS_MAX)
slice_ack  input  1  consumer finished with presented slice
flush_done  output  1  1-cycle pulse when a flush has been fully processed
busy  output  1  any bank not EMPTY

Behaviour:
- Reset (reset=1 at clock edge): both banks EMPTY, write bank = 0, read bank = 0, block counts 0; outputs: blk_ready=0, wr_en=0, wr_bank=0, wr_counter=0, slice_valid=0, slice_bank=0, slice_blocks=0, flush_done=0, busy=0. Reset mid-slice discards all content; no slice_valid emitted. blk_ready rises on the first cycle after reset deasserts.
- Per-bank state: EMPTY -> FILLING (first accepted block) -> FULL (last block written or flush) -> EMPTY (slice_ack while presented). Banks are filled and presented strictly alternately 0,1,0,1...
- Target latch: blocks_per_slice sampled when a bank goes EMPTY->FILLING; value 0 or > BLOCKS_MAX treated as BLOCKS_MAX. Changes mid-slice ignored.
- blk_ready (registered) = 1 iff write bank is EMPTY or FILLING with count < target, and no close pending. Accept = blk_valid & blk_ready.
- Write timing: accept at edge T -> wr_en=1, wr_bank, wr_counter = count-before-accept during cycle T+1 (exactly one cycle). Upstream holds block data stable through T+1. Count increments at T.
- Slice close on count reaching target: bank FULL at T+1 write edge; blk_ready=0 from T+1; write bank toggles. slice_valid for that bank asserted from T+2 (memory write committed), slice_blocks=target.
- Next bank: if other bank EMPTY, blk_ready=1 from T+2; else blk_ready stays 0 until that bank is freed by slice_ack; freed bank usable the cycle after ack.
- Presentation: slice_valid held with stable slice_bank/slice_blocks until slice_ack. Ack with slice_valid=0 ignored. Ack frees bank at that edge; if the other bank is FULL, slice_valid stays 1 and slice_bank/slice_blocks switch on the next cycle.
- Flush: if write bank FILLING with count>0, close it as above with slice_blocks=count; flush_done pulses the cycle slice_valid would first rise. Block accepted same cycle as flush is included before closing. Flush with no blocks pending: no-op, flush_done next cycle. Flush while previous close pending is ignored except for a flush_done pulse.
- Simultaneous last-block close and slice_ack on the other bank: both honoured; new bank fill starts cycle after.
- wr_counter zero-extended to 32 bits; never exceeds BLOCKS_MAX-1.
- busy = either bank FILLING or FULL.

Test Plan:
- Reset then blocks_per_slice=4, 4 blocks back-to-back -> wr_en on 4 consecutive cycles, wr_counter 0,1,2,3, wr_bank=0; slice_valid=1 two cycles after last accept, slice_bank=0, slice_blocks=4.
- Continuous stream of 12 blocks, target 4, slice_ack withheld -> bank1 fills (counter 0..3), then blk_ready=0; ack bank0 -> slice_bank switches to 1, blk_ready=1 next cycle, bank0 refills.
- Target 32, 5 blocks then flush -> slice_blocks=5, flush_done and slice_valid rise same cycle; flush with empty bank -> flush_done only.
- blocks_per_slice=0 and 40 -> slices close at 32 blocks, wr_counter max 31.
- blocks_per_slice changed 8->2 mid-slice -> current slice still closes at 8; next slice closes at 2.
- Reset asserted after 3 of 4 blocks -> all outputs reset values next cycle, no slice_valid; new slice starts at wr_counter=0, bank0.
